traffic_lamp_monitor: RTL and testbench
=======================================

Name: traffic_lamp_monitor

Overview:
Independent watchdog on the lamp outputs of the four-phase traffic controller (NS green+left, NS yellow, EW green+left, EW yellow). It decodes the 8 lamp lines back into a phase and checks three things: legal lamp patterns, legal phase order, and dwell time per phase. On the first violation it latches a fault code and drives a fail-safe flashing-red output. Sits beside the controller at the intersection top level and consumes the controller's outputs directly.

Parameters:
GREEN_MIN, 4, minimum legal dwell of a green phase (P0/P2), in clk cycles
GREEN_MAX, 8, maximum legal dwell of a green phase, in cycles
YELLOW_MIN, 2, minimum legal dwell of a yellow phase (P1/P3), in cycles
YELLOW_MAX, 5, maximum legal dwell of a yellow phase, in cycles
FLASH_DIV, 4, flash_red half-period in cycles
CNT_W, 5, dwell counter width; must hold GREEN_MAX+1 and YELLOW_MAX+1

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
Red_NS, Yellow_NS, Green_NS, freeLeft_NE_SW  in  1 each  NS lamp lines from controller
Red_EW, Yellow_EW, Green_EW, freeLeft_ES_WN  in  1 each  EW lamp lines from controller
clear_fault  in  1  request to leave FAULT; sampled one cycle at a time
phase  out  2  decoded current phase, P0..P3
phase_valid  out  1  high when in TRACK
fault  out  1  latched fault flag
fault_code  out  3  0 none, 1 illegal pattern, 2 bad sequence, 3 short dwell, 4 stuck (long dwell)
flash_red  out  1  fail-safe flashing red; 0 outside FAULT

Behaviour:
- Clock and reset: reset is asynchronous and active-high; clk is the clock. Reset values: phase=0, phase_valid=0, fault=0, fault_code=0, flash_red=0, FSM=SYNC, dwell=0.
- Latency: all outputs are registered. A condition on the inputs sampled at edge k is visible after edge k.
- Legal patterns, listed as {R_NS,Y_NS,G_NS,L_NS,R_EW,Y_EW,G_EW,L_EW}:
  - P0 = 0011_1000
  - P1 = 0100_1000
  - P2 = 1000_0011
  - P3 = 1000_0100
  - Any other vector is illegal.
- Dwell counter: set to 1 in the first cycle of a phase, then +1 per cycle while the pattern is unchanged. It saturates at all-ones.
- FSM, SYNC state:
  - phase_valid=0; no checks performed, illegal patterns ignored.
  - On the first legal pattern: go to TRACK, phase=that pattern, dwell=1, first_phase=1.
- FSM, TRACK state:
  - Runs all checks each cycle. Each fault sets fault=1 with the code below and moves to FAULT.
  - Illegal pattern: code 1.
  - Pattern change to anything other than (phase+1) mod 4: code 2.
  - Pattern change to the correct successor with prior dwell < MIN for the old phase: code 3. Suppressed when first_phase=1, because that phase was entered part-way through.
  - Pattern unchanged and dwell would become MAX+1: code 4. Applies also when first_phase=1.
  - Legal advance: phase updates, dwell=1, first_phase=0.
  - Priority when several apply in one cycle: 1 > 2 > 3 > 4.
- FSM, FAULT state:
  - fault and fault_code are held; phase holds its last value; phase_valid=0.
  - flash_red starts at 1 on entry and toggles every FLASH_DIV cycles (default period 8).
  - clear_fault=1 with a legal input pattern: go to SYNC next cycle, fault=0, fault_code=0, flash_red=0.
  - clear_fault with an illegal pattern is ignored.
  - Further violations do not overwrite the code.
- clear_fault in SYNC or TRACK: no effect.
- Reset in any state, including mid-FAULT: immediate return to reset values.

Optional Feature:
Macro: TRAFFIC_MONITOR_STATS_EN.
- Defined: adds output port cycles_done [15:0], reset 0. It increments on every legal P3->P0 advance in TRACK and wraps from 0xFFFF to 0. It holds in FAULT and clears to 0 on fault clear.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package traffic_pkg holds:
  - phase encodings P0..P3 (2-bit)
  - the four legal 8-bit lamp pattern constants and the bit order above
  - fault code constants FLT_NONE, FLT_ILLEGAL, FLT_SEQ, FLT_SHORT, FLT_STUCK
  - monitor FSM state encoding SYNC/TRACK/FAULT
- One sub-module, traffic_flasher: a FLASH_DIV-parameterised toggle divider with enable; enable low forces output 0 and clears its count.

Test Plan:
1. Legal loop with dwells P0=6, P1=3, P2=6, P3=3 for 3 rounds -> fault=0 throughout; phase tracks the input with 1-cycle lag; phase_valid=1 from the cycle after the first legal sample.
2. In P0 at dwell 3, drive Green_NS and Green_EW both high for one cycle -> next cycle fault=1, code=1, flash_red=1; flash_red toggles every 4 cycles.
3. Tracked P0 of dwell 5, then jump to P2 -> code 2. Repeat with a tracked P1 of dwell 1 then P2 -> code 3.
4. Hold P0 with dwell counted from a tracked entry -> fault with code 4 visible after the 9th sampled cycle of P0. A first (SYNC-entered) P0 of dwell 1 advancing to P1 -> no fault.
5. In FAULT, assert clear_fault with an illegal pattern -> stays in FAULT. Assert clear_fault with P2 -> SYNC, fault=0, flash_red=0, then resumes tracking at P2.
6. Assert reset mid-FAULT and mid-TRACK -> all outputs 0 immediately. With TRAFFIC_MONITOR_STATS_EN defined, 3 legal rounds -> cycles_done=3.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared encodings for the traffic lamp monitor.
// Holds the phase codes, the four legal lamp patterns, the fault codes
// and the monitor FSM states.
// Lamp vector bit order: {R_NS,Y_NS,G_NS,L_NS,R_EW,Y_EW,G_EW,L_EW}.
package traffic_pkg;
    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;
    localparam logic [1:0] P3 = 2'd3;

    localparam logic [7:0] PAT_P0 = 8'b0011_1000;
    localparam logic [7:0] PAT_P1 = 8'b0100_1000;
    localparam logic [7:0] PAT_P2 = 8'b1000_0011;
    localparam logic [7:0] PAT_P3 = 8'b1000_0100;

    localparam logic [2:0] FLT_NONE    = 3'd0;
    localparam logic [2:0] FLT_ILLEGAL = 3'd1;
    localparam logic [2:0] FLT_SEQ     = 3'd2;
    localparam logic [2:0] FLT_SHORT   = 3'd3;
    localparam logic [2:0] FLT_STUCK   = 3'd4;

    typedef enum logic [1:0] {SYNC, TRACK, FAULT} mon_state_t;

    // Returns {legal, phase}; phase is 0 when the pattern is illegal.
    function automatic logic [2:0] decode(input logic [7:0] l);
        return l == PAT_P0 ? {1'b1, P0} :
               l == PAT_P1 ? {1'b1, P1} :
               l == PAT_P2 ? {1'b1, P2} :
               l == PAT_P3 ? {1'b1, P3} : 3'b000;
    endfunction
endpackage

// File: rtl/traffic_lamp_monitor_if.sv
// traffic_lamp_monitor_if: lamp lines, clear request and monitor status.
// master: drives the eight lamp lines and clear_fault, reads status.
// slave:  the monitor; reads lamps/clear_fault, drives phase, phase_valid,
//         fault, fault_code, flash_red (and cycles_done when
//         TRAFFIC_MONITOR_STATS_EN is defined).
interface traffic_lamp_monitor_if;
    logic Red_NS, Yellow_NS, Green_NS, freeLeft_NE_SW;
    logic Red_EW, Yellow_EW, Green_EW, freeLeft_ES_WN;
    logic clear_fault;
    logic [1:0] phase;
    logic phase_valid;
    logic fault;
    logic [2:0] fault_code;
    logic flash_red;
`ifdef TRAFFIC_MONITOR_STATS_EN
    logic [15:0] cycles_done;
`endif

    modport master (
        output Red_NS, Yellow_NS, Green_NS, freeLeft_NE_SW,
        output Red_EW, Yellow_EW, Green_EW, freeLeft_ES_WN,
        output clear_fault,
        input  phase, phase_valid, fault, fault_code, flash_red
`ifdef TRAFFIC_MONITOR_STATS_EN
        , input cycles_done
`endif
    );

    modport slave (
        input  Red_NS, Yellow_NS, Green_NS, freeLeft_NE_SW,
        input  Red_EW, Yellow_EW, Green_EW, freeLeft_ES_WN,
        input  clear_fault,
        output phase, phase_valid, fault, fault_code, flash_red
`ifdef TRAFFIC_MONITOR_STATS_EN
        , output cycles_done
`endif
    );
endinterface

// File: rtl/traffic_flasher.sv
// traffic_flasher: toggle divider for the fail-safe flashing red.
// Ports: clk, reset (async, active-high), en (run), flash (registered out).
// Output rises to 1 on the first enabled cycle and toggles every FLASH_DIV
// cycles; en low forces 0 and clears the count.
module traffic_flasher #(
    parameter int FLASH_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic flash
);
    localparam int W = $clog2(FLASH_DIV + 1);
    logic [W-1:0] cnt;
    // cnt==0 marks "just enabled"; while running it cycles 1..FLASH_DIV.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            flash <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            flash <= 1'b0;
        end else if (cnt == '0) begin
            cnt   <= W'(1);
            flash <= 1'b1;
        end else if (cnt == W'(FLASH_DIV)) begin
            cnt   <= W'(1);
            flash <= ~flash;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/traffic_lamp_monitor.sv
// traffic_lamp_monitor: watchdog on the traffic controller lamp outputs.
// Ports: clk, reset (async, active-high), mon (traffic_lamp_monitor_if.slave):
//   lamps + clear_fault in; phase, phase_valid, fault, fault_code, flash_red out.
// Checks lamp pattern legality, phase order and per-phase dwell; latches the
// first fault and flashes red until cleared with a legal pattern.
// Optional: TRAFFIC_MONITOR_STATS_EN adds cycles_done (completed P3->P0 laps).
import traffic_pkg::*;

module traffic_lamp_monitor #(
    parameter int GREEN_MIN  = 4,
    parameter int GREEN_MAX  = 8,
    parameter int YELLOW_MIN = 2,
    parameter int YELLOW_MAX = 5,
    parameter int FLASH_DIV  = 4,
    parameter int CNT_W      = 5
) (
    input logic clk,
    input logic reset,
    traffic_lamp_monitor_if.slave mon
);
    logic [7:0] lamps;
    logic legal;
    logic [1:0] dec, phase, nxt_phase;
    mon_state_t st;
    logic phase_valid, fault, first_phase, clr, flash_en;
    logic [2:0] fault_code, viol;
    logic [CNT_W-1:0] dwell, dmin, dmax;
`ifdef TRAFFIC_MONITOR_STATS_EN
    logic [15:0] cycles_done;
    assign mon.cycles_done = cycles_done;
`endif

    assign lamps = {mon.Red_NS, mon.Yellow_NS, mon.Green_NS, mon.freeLeft_NE_SW,
                    mon.Red_EW, mon.Yellow_EW, mon.Green_EW, mon.freeLeft_ES_WN};
    assign {legal, dec} = decode(lamps);
    assign nxt_phase = phase + 2'd1;
    // Odd phases are the yellow phases.
    assign dmin = phase[0] ? CNT_W'(YELLOW_MIN) : CNT_W'(GREEN_MIN);
    assign dmax = phase[0] ? CNT_W'(YELLOW_MAX) : CNT_W'(GREEN_MAX);

    // Violation in priority order; only acted on in TRACK.
    always_comb
        viol = !legal                                           ? FLT_ILLEGAL :
               (dec != phase && dec != nxt_phase)               ? FLT_SEQ :
               (dec == nxt_phase && !first_phase && dwell < dmin) ? FLT_SHORT :
               (dec == phase && dwell == dmax)                  ? FLT_STUCK : FLT_NONE;

    assign clr = st == FAULT && mon.clear_fault && legal;
    // Flasher runs off the next state so flash_red is 1 on the same edge fault rises.
    assign flash_en = st == FAULT ? !clr : st == TRACK && viol != FLT_NONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st          <= SYNC;
            phase       <= P0;
            phase_valid <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= FLT_NONE;
            dwell       <= '0;
            first_phase <= 1'b0;
`ifdef TRAFFIC_MONITOR_STATS_EN
            cycles_done <= '0;
`endif
        end else begin
            case (st)
                SYNC: if (legal) begin
                    st          <= TRACK;
                    phase       <= dec;
                    phase_valid <= 1'b1;
                    dwell       <= CNT_W'(1);
                    first_phase <= 1'b1;
                end
                TRACK: if (viol != FLT_NONE) begin
                    st          <= FAULT;
                    fault       <= 1'b1;
                    fault_code  <= viol;
                    phase_valid <= 1'b0;
                end else if (dec != phase) begin
                    phase       <= dec;
                    dwell       <= CNT_W'(1);
                    first_phase <= 1'b0;
`ifdef TRAFFIC_MONITOR_STATS_EN
                    if (phase == P3) cycles_done <= cycles_done + 16'd1;
`endif
                end else begin
                    dwell <= &dwell ? dwell : dwell + 1'b1;
                end
                FAULT: if (clr) begin
                    st         <= SYNC;
                    fault      <= 1'b0;
                    fault_code <= FLT_NONE;
`ifdef TRAFFIC_MONITOR_STATS_EN
                    cycles_done <= '0;
`endif
                end
                default: st <= SYNC;
            endcase
        end
    end

    traffic_flasher #(.FLASH_DIV(FLASH_DIV)) u_flasher (
        .clk  (clk),
        .reset(reset),
        .en   (flash_en),
        .flash(mon.flash_red)
    );

    assign mon.phase       = phase;
    assign mon.phase_valid = phase_valid;
    assign mon.fault       = fault;
    assign mon.fault_code  = fault_code;
endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// tb_traffic_lamp_monitor: self-checking bench for traffic_lamp_monitor.
// Table vectors with hand-derived expectations, hand sequences for the
// multi-cycle corners, and random stimulus against a behavioural model.
module tb_traffic_lamp_monitor;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int passed = 0;

    traffic_lamp_monitor_if bus ();
    traffic_lamp_monitor dut (.clk(clk), .reset(reset), .mon(bus));

    always #5 clk = ~clk;

    logic [7:0] pats [4] = '{8'h38, 8'h48, 8'h83, 8'h84};

    // Behavioural model: 0 sync, 1 track, 2 fault
    int m_st, m_ph, m_dw, m_first, m_fault, m_code, m_age, m_cyc;

    typedef struct {
        logic [7:0] pat;
        logic       clr;
        int         e_phase;
        int         e_valid;
        int         e_fault;
        int         e_code;
    } vec_t;
    vec_t vecs [12];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int pat_idx(input logic [7:0] p);
        for (int i = 0; i < 4; i++) if (p == pats[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_st = 0; m_ph = 0; m_dw = 0; m_first = 0;
        m_fault = 0; m_code = 0; m_age = 0; m_cyc = 0;
    endtask

    task automatic model_step(input logic [7:0] p, input logic clr);
        int idx, code, mn, mx;
        idx = pat_idx(p);
        mn = (m_ph % 2 == 0) ? 4 : 2;
        mx = (m_ph % 2 == 0) ? 8 : 5;
        if (m_st == 0) begin
            if (idx >= 0) begin m_st = 1; m_ph = idx; m_dw = 1; m_first = 1; end
        end else if (m_st == 1) begin
            code = 0;
            if (idx < 0) code = 1;
            else if (idx != m_ph && idx != (m_ph + 1) % 4) code = 2;
            else if (idx == (m_ph + 1) % 4 && m_first == 0 && m_dw < mn) code = 3;
            else if (idx == m_ph && m_dw + 1 > mx) code = 4;
            if (code != 0) begin
                m_st = 2; m_fault = 1; m_code = code; m_age = 0;
            end else if (idx != m_ph) begin
                if (m_ph == 3) m_cyc = (m_cyc + 1) % 65536;
                m_ph = idx; m_dw = 1; m_first = 0;
            end else m_dw++;
        end else begin
            if (clr && idx >= 0) begin m_st = 0; m_fault = 0; m_code = 0; m_cyc = 0; end
            else m_age++;
        end
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".phase"}, int'(bus.phase), m_ph);
        chk({tag, ".valid"}, int'(bus.phase_valid), int'(m_st == 1));
        chk({tag, ".fault"}, int'(bus.fault), m_fault);
        chk({tag, ".code"}, int'(bus.fault_code), m_code);
        chk({tag, ".flash"}, int'(bus.flash_red), int'(m_st == 2 && (m_age / 4) % 2 == 0));
`ifdef TRAFFIC_MONITOR_STATS_EN
        chk({tag, ".cycles"}, int'(bus.cycles_done), m_cyc);
`endif
    endtask

    task automatic drive(input logic [7:0] p, input logic clr);
        {bus.Red_NS, bus.Yellow_NS, bus.Green_NS, bus.freeLeft_NE_SW,
         bus.Red_EW, bus.Yellow_EW, bus.Green_EW, bus.freeLeft_ES_WN} = p;
        bus.clear_fault = clr;
    endtask

    task automatic step(input logic [7:0] p, input logic clr, input string tag);
        drive(p, clr);
        @(posedge clk);
        #1;
        model_step(p, clr);
        cmp_model(tag);
    endtask

    task automatic zeros(input string tag);
        chk({tag, ".phase"}, int'(bus.phase), 0);
        chk({tag, ".valid"}, int'(bus.phase_valid), 0);
        chk({tag, ".fault"}, int'(bus.fault), 0);
        chk({tag, ".code"}, int'(bus.fault_code), 0);
        chk({tag, ".flash"}, int'(bus.flash_red), 0);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        model_reset();
        zeros(tag);
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        logic [7:0] cur;
        int r;
        model_reset();
        drive(8'h00, 1'b0);
        vecs[0]  = '{8'h84, 1'b0, 3, 1, 0, 0};
        vecs[1]  = '{8'h38, 1'b0, 0, 1, 0, 0};
        vecs[2]  = '{8'h38, 1'b0, 0, 1, 0, 0};
        vecs[3]  = '{8'h38, 1'b0, 0, 1, 0, 0};
        vecs[4]  = '{8'h83, 1'b0, 0, 0, 1, 2};
        vecs[5]  = '{8'h83, 1'b1, 0, 0, 0, 0};
        vecs[6]  = '{8'h38, 1'b0, 0, 1, 0, 0};
        vecs[7]  = '{8'h48, 1'b0, 1, 1, 0, 0};
        vecs[8]  = '{8'h83, 1'b0, 1, 0, 1, 3};
        vecs[9]  = '{8'hFF, 1'b1, 1, 0, 1, 3};
        vecs[10] = '{8'h83, 1'b1, 1, 0, 0, 0};
        vecs[11] = '{8'h83, 1'b0, 2, 1, 0, 0};

        repeat (2) @(posedge clk);
        #1 zeros("reset");
        #1 reset = 1'b0;

        // Legal loop, three rounds plus closing P0
        for (int k = 0; k < 3; k++)
            for (int p = 0; p < 4; p++)
                repeat (p % 2 == 0 ? 6 : 3) step(pats[p], 1'b0, "loop");
        step(pats[0], 1'b0, "loop_end");
        chk("loop.no_fault", int'(bus.fault), 0);
`ifdef TRAFFIC_MONITOR_STATS_EN
        chk("loop.cycles_done", int'(bus.cycles_done), 3);
`endif

        // Table vectors: sequence error, short dwell, clear handling
        do_reset("rst_track");
        foreach (vecs[i]) begin
            step(vecs[i].pat, vecs[i].clr, "vec");
            chk($sformatf("vec%0d.phase", i), int'(bus.phase), vecs[i].e_phase);
            chk($sformatf("vec%0d.valid", i), int'(bus.phase_valid), vecs[i].e_valid);
            chk($sformatf("vec%0d.fault", i), int'(bus.fault), vecs[i].e_fault);
            chk($sformatf("vec%0d.code", i), int'(bus.fault_code), vecs[i].e_code);
        end

        // Illegal pattern mid-P0, flash cadence, no overwrite of code
        do_reset("rst_track2");
        step(pats[3], 1'b0, "ill");
        repeat (3) step(pats[0], 1'b0, "ill");
        step(8'h3A, 1'b0, "ill_hit");
        chk("ill.code", int'(bus.fault_code), 1);
        chk("ill.flash_entry", int'(bus.flash_red), 1);
        for (int c = 1; c < 12; c++) begin
            step(c < 6 ? 8'hFF : pats[2], 1'b0, "flash");
            chk($sformatf("flash.c%0d", c), int'(bus.flash_red), int'((c / 4) % 2 == 0));
        end
        chk("ill.code_held", int'(bus.fault_code), 1);

        // Stuck P0: tracked entry, fault after 9th sample
        do_reset("rst_fault");
        step(pats[3], 1'b0, "stuck");
        repeat (8) step(pats[0], 1'b0, "stuck");
        chk("stuck.8th", int'(bus.fault), 0);
        step(pats[0], 1'b0, "stuck_hit");
        chk("stuck.code", int'(bus.fault_code), 4);

        // Randomised run against the model
        cur = pats[0];
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 70) cur = cur;
            else if (r < 90) cur = pats[(pat_idx(cur) < 0 ? 0 : pat_idx(cur) + 1) % 4];
            else if (r < 96) cur = pats[$urandom_range(0, 3)];
            else cur = 8'($urandom);
            step(cur, $urandom_range(0, 9) == 0, "rand");
            if (n == 300) do_reset("rst_rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
